// File: rtl/jt51_phase_pipe_pkg.sv
// jt51_phase_pipe shared constants, detune tables and stage bundles.
// JT51_PG_DISPLAY_STEP_EN (see top) adds a step print in simulation.
package jt51_phase_pipe_pkg;

  localparam logic [7:0]  DT2_LIM2 = 8'd75;
  localparam logic [7:0]  DT2_LIM3 = 8'd95;
  localparam logic [17:0] BASE_MAX = 18'd82976;

  typedef struct packed {
    logic [13:0] kc2;
    logic [2:0]  dt1;
  } s1_t;

  typedef struct packed {
    logic [9:0] addr;
    logic [3:0] oct;
    logic [5:0] dtkf;
    logic [2:0] dt1;
  } s2_t;

  typedef struct packed {
    logic [17:0] base;
    logic [4:0]  pow2;
    logic [2:0]  dtsh;
    logic [2:0]  dt1;
  } s3_t;

  typedef struct packed {
    logic [17:0] base;
    logic [4:0]  off;
    logic [2:0]  dt1;
  } s4_t;

  function automatic logic [4:0] pow2_lut(
    input logic [2:0] i
  );
    unique case (i)
      3'd0: pow2_lut = 5'd16;
      3'd1: pow2_lut = 5'd17;
      3'd2: pow2_lut = 5'd19;
      3'd3: pow2_lut = 5'd20;
      3'd4: pow2_lut = 5'd22;
      3'd5: pow2_lut = 5'd24;
      3'd6: pow2_lut = 5'd26;
      default: pow2_lut = 5'd29;
    endcase
  endfunction

  function automatic logic [4:0] dt1_lim(
    input logic [1:0] m
  );
    unique case (m)
      2'd2: dt1_lim = 5'd16;
      2'd3: dt1_lim = 5'd22;
      default: dt1_lim = 5'd8;
    endcase
  endfunction

  // 6-bit wrap: -4 is encoded as 60
  function automatic logic [5:0] dt1_adj(
    input logic [1:0] m
  );
    unique case (m)
      2'd1: dt1_adj = 6'd60;
      2'd2: dt1_adj = 6'd4;
      2'd3: dt1_adj = 6'd8;
      default: dt1_adj = 6'd0;
    endcase
  endfunction

  function automatic logic [9:0] dt2_off(
    input logic [1:0] d
  );
    unique case (d)
      2'd1: dt2_off = 10'd512;
      2'd2: dt2_off = 10'd628;
      2'd3: dt2_off = 10'd800;
      default: dt2_off = 10'd0;
    endcase
  endfunction

  function automatic logic [8:0] pm_mod(
    input logic [2:0] pms,
    input logic [6:0] pm
  );
    unique case (pms)
      3'd1: pm_mod = {7'd0, pm[6:5]};
      3'd2: pm_mod = {6'd0, pm[6:4]};
      3'd3: pm_mod = {5'd0, pm[6:3]};
      3'd4: pm_mod = {4'd0, pm[6:2]};
      3'd5: pm_mod = {3'd0, pm[6:1]};
      3'd6: pm_mod = {1'b0, pm, 1'b0};
      3'd7: pm_mod = {pm, 2'b00};
      default: pm_mod = 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/jt51_phase_pipe_if.sv
// Slot bundle between the register/LFO front end and the phase pipe.
// master drives the per-slot operands, slave returns keycode/phase.
interface jt51_phase_pipe_if;
  logic [6:0] kc;
  logic [5:0] kf;
  logic [3:0] mul;
  logic [2:0] dt1;
  logic [1:0] dt2;
  logic [7:0] pm;
  logic [2:0] pms;
  logic       pg_rst_III;
  logic [4:0] keycode_III;
  logic [9:0] ph_X;

  modport master (
    output kc, kf, mul, dt1, dt2,
    output pm, pms, pg_rst_III,
    input  keycode_III, ph_X
  );

  modport slave (
    input  kc, kf, mul, dt1, dt2,
    input  pm, pms, pg_rst_III,
    output keycode_III, ph_X
  );
endinterface

// File: rtl/jt51_phinc_rom.sv
// One-octave phase increment table: 16 anchors per octave, linear in kf.
module jt51_phinc_rom (
  input  logic [9:0]  i_addr,
  output logic [11:0] o_phinc
);
  logic [11:0] w_lo;
  logic [11:0] w_hi;
  logic [11:0] w_delta;
  logic [12:0] w_prod;

  function automatic logic [11:0] anchor(
    input logic [4:0] n
  );
    unique case (n)
      5'd0:  anchor = 12'd1299;
      5'd1:  anchor = 12'd1357;
      5'd2:  anchor = 12'd1417;
      5'd3:  anchor = 12'd1479;
      5'd4:  anchor = 12'd1545;
      5'd5:  anchor = 12'd1613;
      5'd6:  anchor = 12'd1685;
      5'd7:  anchor = 12'd1759;
      5'd8:  anchor = 12'd1837;
      5'd9:  anchor = 12'd1918;
      5'd10: anchor = 12'd2003;
      5'd11: anchor = 12'd2092;
      5'd12: anchor = 12'd2185;
      5'd13: anchor = 12'd2281;
      5'd14: anchor = 12'd2382;
      5'd15: anchor = 12'd2488;
      default: anchor = 12'd2598;
    endcase
  endfunction

  assign w_lo    = anchor({1'b0, i_addr[9:6]});
  assign w_hi    = anchor({1'b0, i_addr[9:6]} + 5'd1);
  assign w_delta = w_hi - w_lo;
  assign w_prod  = {1'b0, w_delta} * {7'd0, i_addr[5:0]};
  assign o_phinc = w_lo + 12'(w_prod >> 6);
endmodule

// File: rtl/jt51_pm.sv
// Applies LFO PM to {kc,kf}; saturates at both ends of the 13-bit range.
module jt51_pm (
  input  logic [6:0]  i_kc,
  input  logic [5:0]  i_kf,
  input  logic [8:0]  i_mod,
  input  logic        i_add,
  output logic [12:0] o_kcex
);
  logic [13:0] w_in;
  logic [13:0] w_sum;

  assign w_in = {1'b0, i_kc, i_kf};

  always_comb begin
    w_sum  = '0;
    o_kcex = '0;
    if (i_add) begin
      w_sum  = w_in + {5'd0, i_mod};
      o_kcex = w_sum[13] ? 13'h1fff : w_sum[12:0];
    end else begin
      w_sum  = w_in - {5'd0, i_mod};
      o_kcex = w_sum[13] ? 13'h0000 : w_sum[12:0];
    end
  end
endmodule

// File: rtl/jt51_sh.sv
// Fixed-length shift register delay line with async reset.
module jt51_sh #(
  parameter int W = 5,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_drop
);
  logic [N-1:0][W-1:0] r_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sh <= '0;
    else     r_sh <= {r_sh[N-2:0], i_din};
  end

  assign o_drop = r_sh[N-1];
endmodule

// File: rtl/jt51_phase_pipe.sv
// JT51 per-slot phase generator: keycode/detune/MUL to a 32-slot ring.
// JT51_PG_DISPLAY_STEP_EN: simulation prints the step every clock.
module jt51_phase_pipe
  import jt51_phase_pipe_pkg::*;
(
  input logic              clk,
  input logic              rst,
  jt51_phase_pipe_if.slave bus
);
  s1_t         r_s1;
  s2_t         r_s2;
  s3_t         r_s3;
  s4_t         r_s4;
  logic [4:0]  r_keycode;
  logic [19:0] r_b20;
  logic [19:0] r_step;
  logic [19:0] r_acc;
  logic [9:0]  r_ph1;
  logic [9:0]  r_ph2;

  logic [8:0]  w_mod;
  logic [12:0] w_kci;
  logic        w_extra;
  logic [13:0] w_kc2;
  logic [11:0] w_phinc;
  logic [17:0] w_ph18;
  logic [17:0] w_base;
  logic [5:0]  w_p6;
  logic [5:0]  w_off;
  logic [4:0]  w_lim;
  logic [4:0]  w_offc;
  logic [19:0] w_b20;
  logic [19:0] w_o20;
  logic [19:0] w_base20;
  logic [19:0] w_step;
  logic [3:0]  w_mul_vi;
  logic        w_pg_vii;
  logic [19:0] w_ring;

  assign w_mod = pm_mod(bus.pms, bus.pm[6:0]);

  jt51_pm u_pm (
    .i_kc   (bus.kc),
    .i_kf   (bus.kf),
    .i_mod  (w_mod),
    .i_add  (~bus.pm[7]),
    .o_kcex (w_kci)
  );

  always_comb begin
    w_extra = 1'b0;
    unique case (bus.dt2)
      2'd2:    w_extra = w_kci[7:0] > DT2_LIM2;
      2'd3:    w_extra = w_kci[7:0] > DT2_LIM3;
      default: w_extra = &w_kci[7:6];
    endcase
  end

  assign w_kc2 = {1'b0, w_kci}
               + {4'd0, dt2_off(bus.dt2)}
               + {7'd0, w_extra, 6'd0};

  jt51_phinc_rom u_rom (
    .i_addr  (r_s2.addr),
    .o_phinc (w_phinc)
  );

  assign w_ph18 = {6'd0, w_phinc};

  always_comb begin
    w_base = '0;
    unique case (r_s2.oct)
      4'd0:    w_base = w_ph18 >> 2;
      4'd1:    w_base = w_ph18 >> 1;
      4'd2:    w_base = w_ph18;
      4'd3:    w_base = w_ph18 << 1;
      4'd4:    w_base = w_ph18 << 2;
      4'd5:    w_base = w_ph18 << 3;
      4'd6:    w_base = w_ph18 << 4;
      4'd7:    w_base = w_ph18 << 5;
      4'd8:    w_base = w_ph18 << 6;
      default: w_base = '0;
    endcase
  end

  assign w_p6  = {1'b0, r_s3.pow2};
  assign w_lim = dt1_lim(r_s3.dt1[1:0]);

  always_comb begin
    w_off = '0;
    unique case (r_s3.dtsh)
      3'd0:    w_off = w_p6 >> 4;
      3'd1:    w_off = w_p6 >> 3;
      3'd2:    w_off = w_p6 >> 2;
      3'd3:    w_off = w_p6 >> 1;
      3'd4:    w_off = w_p6;
      3'd5:    w_off = w_p6 << 1;
      default: w_off = '0;
    endcase
  end

  assign w_offc = (w_off > {1'b0, w_lim}) ? w_lim : w_off[4:0];

  assign w_b20 = {2'b00, r_s4.base};
  assign w_o20 = {15'd0, r_s4.off};

  always_comb begin
    w_base20 = w_b20;
    if (r_s4.dt1[1:0] != 2'd0) begin
      if (r_s4.dt1[2]) w_base20 = w_b20 - w_o20;
      else             w_base20 = w_b20 + w_o20;
    end
  end

  jt51_sh #(.W(4), .N(5)) u_mul_dly (
    .clk    (clk),
    .rst    (rst),
    .i_din  (bus.mul),
    .o_drop (w_mul_vi)
  );

  // mul = 0 means a half-speed operator
  assign w_step = (w_mul_vi == 4'd0)
                ? {1'b0, r_b20[19:1]}
                : r_b20 * {16'd0, w_mul_vi};

  jt51_sh #(.W(1), .N(4)) u_pg_dly (
    .clk    (clk),
    .rst    (rst),
    .i_din  (bus.pg_rst_III),
    .o_drop (w_pg_vii)
  );

  // acc register plus 31 ring stages closes the 32-slot loop
  jt51_sh #(.W(20), .N(31)) u_ring (
    .clk    (clk),
    .rst    (rst),
    .i_din  (r_acc),
    .o_drop (w_ring)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3      <= '0;
      r_s4      <= '0;
      r_keycode <= '0;
      r_b20     <= '0;
      r_step    <= '0;
      r_acc     <= '0;
      r_ph1     <= '0;
      r_ph2     <= '0;
    end else begin
      r_s1.kc2   <= w_kc2;
      r_s1.dt1   <= bus.dt1;
      r_s2.addr  <= r_s1.kc2[9:0];
      r_s2.oct   <= r_s1.kc2[13:10];
      r_s2.dtkf  <= r_s1.kc2[13:8]
                  + dt1_adj(r_s1.dt1[1:0]);
      r_s2.dt1   <= r_s1.dt1;
      r_keycode  <= r_s1.kc2[12:8];
      r_s3.base  <= w_base;
      r_s3.pow2  <= pow2_lut(r_s2.dtkf[2:0]);
      r_s3.dtsh  <= r_s2.dtkf[5:3];
      r_s3.dt1   <= r_s2.dt1;
      r_s4.base  <= (r_s3.base > BASE_MAX)
                  ? BASE_MAX : r_s3.base;
      r_s4.off   <= w_offc;
      r_s4.dt1   <= r_s3.dt1;
      r_b20      <= w_base20;
      r_step     <= w_step;
      r_acc      <= w_pg_vii ? 20'd0 : w_ring + r_step;
      r_ph1      <= r_acc[9:0];
      r_ph2      <= r_ph1;
    end
  end

  assign bus.keycode_III = r_keycode;
  assign bus.ph_X        = r_ph2;

`ifdef JT51_PG_DISPLAY_STEP_EN
  always @(posedge clk) $display("%0d", r_step);
`else
`endif

endmodule

// File: tb/tb_jt51_phase_pipe.sv
// Randomised and directed slot streams checked against a per-slot model.
module tb_jt51_phase_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;

  jt51_phase_pipe_if bus ();

  jt51_phase_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc;
  int m_acc [32];
  logic [9:0] e_ph [4096];
  logic [4:0] e_kc [4096];
  bit pg_plan [4096];

  int anchor [17] = '{1299, 1357, 1417, 1479, 1545, 1613,
                      1685, 1759, 1837, 1918, 2003, 2092,
                      2185, 2281, 2382, 2488, 2598};
  int pw [8]    = '{16, 17, 19, 20, 22, 24, 26, 29};
  int lim [4]   = '{8, 8, 16, 22};
  int dtoff [4] = '{0, 512, 628, 800};
  int adj [4]   = '{0, -4, 4, 8};

  function automatic void model(
    input int kc, kf, mul, dt1, dt2, pm, pms,
    output int kc2, output int step
  );
    int mag, md, kin, kci, extra, addr, n, f;
    int ph, oct, base, d1m, dtkf, sh, off, b20;
    mag = pm % 128;
    case (pms)
      0: md = 0;
      1: md = mag / 32;
      2: md = mag / 16;
      3: md = mag / 8;
      4: md = mag / 4;
      5: md = mag / 2;
      6: md = mag * 2;
      default: md = mag * 4;
    endcase
    kin = kc * 64 + kf;
    if (pm < 128) kci = (kin + md > 8191) ? 8191 : kin + md;
    else          kci = (kin < md) ? 0 : kin - md;
    case (dt2)
      2: extra = (kci % 256 > 75) ? 1 : 0;
      3: extra = (kci % 256 > 95) ? 1 : 0;
      default: extra = ((kci / 64) % 4 == 3) ? 1 : 0;
    endcase
    kc2 = kci + dtoff[dt2] + 64 * extra;
    addr = kc2 % 1024;
    n = addr / 64;
    f = addr % 64;
    ph = anchor[n] + (anchor[n+1] - anchor[n]) * f / 64;
    oct = kc2 / 1024;
    base = (oct > 8) ? 0 : ph * (1 << oct) / 4;
    if (base > 82976) base = 82976;
    d1m = dt1 % 4;
    dtkf = ((kc2 / 256) % 64 + 64 + adj[d1m]) % 64;
    sh = dtkf / 8;
    off = (sh > 5) ? 0 : pw[dtkf % 8] * (1 << sh) / 16;
    if (off > lim[d1m]) off = lim[d1m];
    if (d1m == 0)      b20 = base;
    else if (dt1 >= 4) b20 = (base - off) & 1048575;
    else               b20 = (base + off) & 1048575;
    step = (mul == 0) ? b20 / 2 : (b20 * mul) % 1048576;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_acc[i] = 0;
    cyc = 0;
  endtask

  task automatic chk_zero(input string tag);
    tests++;
    assert (bus.ph_X === 10'd0) else begin
      fails++;
      $error("FAIL %s ph_X got %0d want 0", tag, bus.ph_X);
    end
    tests++;
    assert (bus.keycode_III === 5'd0) else begin
      fails++;
      $error("FAIL %s keycode got %0d want 0",
             tag, bus.keycode_III);
    end
  endtask

  // modes: 0 random, 1 pg held, 2 top-octave clamp,
  // 3 dt1 +/- pairs, 4 mul 0/2 pairs
  task automatic step_cycle(input int mode);
    int kc, kf, mul, dt1, dt2, pm, pms, kc2, st, s;
    bit pg;
    logic [9:0] x_ph;
    logic [4:0] x_kc;
    kc  = $urandom_range(0, 127);
    kf  = $urandom_range(0, 63);
    mul = $urandom_range(0, 15);
    dt1 = $urandom_range(0, 7);
    dt2 = $urandom_range(0, 3);
    pm  = $urandom_range(0, 255);
    pms = $urandom_range(0, 7);
    pg  = ($urandom_range(0, 15) == 0);
    case (mode)
      1: pg = 1'b1;
      2: begin
        kc = 127; kf = 63; dt2 = 1; pms = 0;
        dt1 = 0; mul = 1; pg = 1'b0;
      end
      3: begin
        kc = 74; kf = 20; dt2 = 0; pms = 0; mul = 1;
        dt1 = (cyc % 2 == 1) ? 7 : 3; pg = 1'b0;
      end
      4: begin
        kc = 90; kf = 33; dt2 = 2; pms = 0; dt1 = 0;
        mul = (cyc % 2 == 1) ? 2 : 0; pg = 1'b0;
      end
      default: ;
    endcase
    bus.kc  = kc[6:0];
    bus.kf  = kf[5:0];
    bus.mul = mul[3:0];
    bus.dt1 = dt1[2:0];
    bus.dt2 = dt2[1:0];
    bus.pm  = pm[7:0];
    bus.pms = pms[2:0];
    bus.pg_rst_III = (cyc < 2) ? 1'b1 : pg_plan[cyc-2];
    model(kc, kf, mul, dt1, dt2, pm, pms, kc2, st);
    s = cyc % 32;
    pg_plan[cyc] = pg;
    m_acc[s] = pg ? 0 : (m_acc[s] + st) % 1048576;
    e_ph[cyc] = 10'(m_acc[s] % 1024);
    e_kc[cyc] = 5'((kc2 / 256) % 32);
    @(posedge clk);
    #1;
    x_ph = (cyc < 8) ? 10'd0 : e_ph[cyc-8];
    x_kc = (cyc < 1) ? 5'd0 : e_kc[cyc-1];
    tests++;
    assert (bus.ph_X === x_ph) else begin
      fails++;
      $error("FAIL ph_X m%0d cyc=%0d got %0d want %0d",
             mode, cyc, bus.ph_X, x_ph);
    end
    tests++;
    assert (bus.keycode_III === x_kc) else begin
      fails++;
      $error("FAIL keycode m%0d cyc=%0d got %0d want %0d",
             mode, cyc, bus.keycode_III, x_kc);
    end
    cyc++;
  endtask

  initial begin
    bus.kc = '0; bus.kf = '0; bus.mul = '0;
    bus.dt1 = '0; bus.dt2 = '0; bus.pm = '0;
    bus.pms = '0; bus.pg_rst_III = 1'b1;
    #12;
    chk_zero("por");
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 200; i++) step_cycle(0);
    for (int i = 0; i < 70; i++)  step_cycle(1);
    for (int i = 0; i < 100; i++) step_cycle(2);
    for (int i = 0; i < 100; i++) step_cycle(3);
    for (int i = 0; i < 100; i++) step_cycle(4);
    for (int i = 0; i < 100; i++) step_cycle(0);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #1;
    chk_zero("rst_held");
    #2;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 60; i++)  step_cycle(2);
    for (int i = 0; i < 150; i++) step_cycle(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
